// File: rtl/pe_rf_write_arbiter_pkg.sv
// Shared constants and types for the PE register-file write path.
package pe_rf_write_arbiter_pkg;

  localparam int PE_RF_DATA_W   = 16;
  localparam int PE_RF_ADDR_W   = 4;
  localparam int PE_RF_NUM_REGS = 16;
  localparam int PE_RF_NUM_REQ  = 3;

  // Requester slots on the register-file write port.
  typedef enum logic [1:0] {
    RF_REQ_LOAD = 2'd0,
    RF_REQ_MAC  = 2'd1,
    RF_REQ_DMA  = 2'd2
  } rf_req_e;

  // Index width for n entries; never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pe_rf_write_arbiter_rr_arbiter.sv
// Generic round-robin arbiter: the first request at or above ptr wins,
// wrapping to the lowest request when nothing sits at or above ptr.
// Purely combinational, so it can be reused for other shared PE resources.
module pe_rf_write_arbiter_rr_arbiter
  import pe_rf_write_arbiter_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [N-1:0] upper_mask;
  logic [N-1:0] masked_req;
  logic [N-1:0] search_req;

  // Mark the positions at or above the pointer.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign upper_mask[gi] = (IDX_W'(gi) >= ptr);
    end
  endgenerate

  // Requests above the pointer take priority; otherwise wrap around to all.
  assign masked_req = req & upper_mask;
  assign search_req = (|masked_req) ? masked_req : req;

  // Lowest set bit of the search vector becomes the one-hot grant.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (search_req[i]) begin
        gnt     = '0;
        gnt[i]  = 1'b1;
        gnt_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/pe_rf_write_arbiter.sv
// Round-robin share of the PE register-file write port between NUM_REQ
// writers. The granted write is registered for one cycle before it reaches
// the register file; reads that target that in-flight register are flagged.
module pe_rf_write_arbiter
  import pe_rf_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = PE_RF_NUM_REQ,
  parameter int DATA_W   = PE_RF_DATA_W,
  parameter int ADDR_W   = PE_RF_ADDR_W,
  parameter int NUM_REGS = PE_RF_NUM_REGS,
  localparam int GID_W   = idx_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic [GID_W-1:0]          grant_id,
  input  logic [ADDR_W-1:0]         raddr_a,
  input  logic [ADDR_W-1:0]         raddr_b,
  output logic                      hazard_a,
  output logic                      hazard_b,
  output logic [NUM_REGS-1:0]       pend_mask
);

  logic [NUM_REQ-1:0] gnt;
  logic [GID_W-1:0]   gnt_idx;
  logic               handshake;
  logic [ADDR_W-1:0]  addr_slice [NUM_REQ];
  logic [DATA_W-1:0]  data_slice [NUM_REQ];
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  logic [GID_W-1:0]   ptr_reg,      ptr_next;
  logic               rf_we_reg,    rf_we_next;
  logic [ADDR_W-1:0]  rf_waddr_reg, rf_waddr_next;
  logic [DATA_W-1:0]  rf_wdata_reg, rf_wdata_next;
  logic [GID_W-1:0]   grant_id_reg, grant_id_next;

  pe_rf_write_arbiter_rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (GID_W)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (ptr_reg),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Unpack the per-requester address/data slices.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_slice[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign data_slice[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Ready is withheld during reset and flush so no handshake can occur then.
  assign req_ready = (rst_n && !flush) ? gnt : '0;
  assign handshake = |(req_valid & req_ready);

  // One-hot AND-OR select of the winner's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = addr_slice[i];
        sel_data = data_slice[i];
      end
    end
  end

  // Next-state: pointer advance past the winner, output stage capture.
  always_comb begin
    ptr_next      = ptr_reg;
    rf_we_next    = handshake;
    rf_waddr_next = rf_waddr_reg;
    rf_wdata_next = rf_wdata_reg;
    grant_id_next = grant_id_reg;
    if (flush) begin
      ptr_next = '0;
    end else if (handshake) begin
      ptr_next      = (gnt_idx == GID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      rf_waddr_next = sel_addr;
      rf_wdata_next = sel_data;
      grant_id_next = gnt_idx;
    end
  end

  // State registers; reset drops any in-flight write immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg      <= '0;
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
      grant_id_reg <= '0;
    end else begin
      ptr_reg      <= ptr_next;
      rf_we_reg    <= rf_we_next;
      rf_waddr_reg <= rf_waddr_next;
      rf_wdata_reg <= rf_wdata_next;
      grant_id_reg <= grant_id_next;
    end
  end

  assign rf_we    = rf_we_reg;
  assign rf_waddr = rf_waddr_reg;
  assign rf_wdata = rf_wdata_reg;
  assign grant_id = grant_id_reg;

  // In-flight register bitmap; the register file still returns the old value.
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_pend
      assign pend_mask[gi] = rf_we_reg & (rf_waddr_reg == ADDR_W'(gi));
    end
  endgenerate

  assign hazard_a = rf_we_reg & (raddr_a == rf_waddr_reg);
  assign hazard_b = rf_we_reg & (raddr_b == rf_waddr_reg);

endmodule

// File: tb/tb_pe_rf_write_arbiter.sv
// Directed bench for pe_rf_write_arbiter with a behavioural register file.
module tb_pe_rf_write_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 16;
  localparam int AW   = 4;
  localparam int NREG = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic             rf_we;
  logic [AW-1:0]    rf_waddr;
  logic [DW-1:0]    rf_wdata;
  logic [1:0]       grant_id;
  logic [AW-1:0]    raddr_a;
  logic [AW-1:0]    raddr_b;
  logic             hazard_a;
  logic             hazard_b;
  logic [NREG-1:0]  pend_mask;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] rf_model [NREG];
  logic          pending  [NREQ];
  logic [20:0]   held     [NREQ];

  pe_rf_write_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .grant_id  (grant_id),
    .raddr_a   (raddr_a),
    .raddr_b   (raddr_b),
    .hazard_a  (hazard_a),
    .hazard_b  (hazard_b),
    .pend_mask (pend_mask)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural register file: commits on the edge where rf_we is high.
  always @(posedge clk) begin
    if (rst_n && rf_we) rf_model[rf_waddr] <= rf_wdata;
  end

  // One line per register-file write transaction.
  always @(negedge clk) begin
    if (rst_n && rf_we)
      $display("WRITE t=%0t id=%0d addr=%0d data=0x%04h", $time, grant_id, rf_waddr, rf_wdata);
  end

  // Requester protocol: an unaccepted request must stay unchanged.
  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (!rst_n) begin
        pending[i] = 1'b0;
      end else begin
        if (pending[i])
          check_value("req_hold", 32'({req_valid[i], req_addr[i*AW +: AW], req_data[i*DW +: DW]}),
                      32'(held[i]));
        pending[i] = req_valid[i] & ~req_ready[i];
        held[i]    = {req_valid[i], req_addr[i*AW +: AW], req_data[i*DW +: DW]};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_data[i*DW +: DW]  = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = '0;
    flush     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  logic [DW-1:0] rr_data [3];

  initial begin
    for (int i = 0; i < NREG; i++) rf_model[i] = '0;
    for (int i = 0; i < NREQ; i++) begin
      pending[i] = 1'b0;
      held[i]    = '0;
    end
    rr_data[0] = 16'h00A1;
    rr_data[1] = 16'h00B2;
    rr_data[2] = 16'h00C3;
    rst_n   = 1'b0;
    flush   = 1'b0;
    raddr_a = '0;
    raddr_b = '0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;

    // 1: reset with every requester asserting
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i + 1), rr_data[i]);
    repeat (2) @(negedge clk);
    #1;
    check_value("rst_rf_we",    32'(rf_we),     32'd0);
    check_value("rst_ready",    32'(req_ready), 32'd0);
    check_value("rst_pend",     32'(pend_mask), 32'd0);
    check_value("rst_grant_id", 32'(grant_id),  32'd0);
    check_value("rst_waddr",    32'(rf_waddr),  32'd0);
    check_value("rst_wdata",    32'(rf_wdata),  32'd0);
    check_value("rst_hazard_a", 32'(hazard_a),  32'd0);
    rst_n = 1'b1;
    #1;
    check_value("rel_ready", 32'(req_ready), 32'b001);

    // 2: round-robin with all three continuously valid
    for (int k = 0; k < 6; k++) begin
      tick();
      check_value("rr_we",    32'(rf_we),    32'd1);
      check_value("rr_gid",   32'(grant_id), 32'(k % 3));
      check_value("rr_addr",  32'(rf_waddr), 32'((k % 3) + 1));
      check_value("rr_data",  32'(rf_wdata), 32'(rr_data[k % 3]));
      check_value("rr_ready", 32'(req_ready), 32'(1 << ((k + 1) % 3)));
    end

    // 3: single requester, no bubbles, pointer parks at 2
    do_reset();
    set_req(1, 1'b1, 4'd4, 16'h0044);
    #1;
    check_value("single_ready", 32'(req_ready), 32'b010);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_value("single_we",  32'(rf_we),    32'd1);
      check_value("single_gid", 32'(grant_id), 32'd1);
    end
    set_req(1, 1'b0, 4'd0, 16'h0000);
    set_req(0, 1'b1, 4'd8, 16'h0808);
    set_req(2, 1'b1, 4'hC, 16'h0C0C);
    #1;
    check_value("ptr2_ready", 32'(req_ready), 32'b100);
    tick();
    check_value("ptr2_we",  32'(rf_we),    32'd1);
    check_value("ptr2_gid", 32'(grant_id), 32'd2);
    set_req(2, 1'b0, 4'd0, 16'h0000);
    #1;
    check_value("wrap_ready", 32'(req_ready), 32'b001);
    tick();
    check_value("wrap_gid",  32'(grant_id), 32'd0);
    check_value("wrap_addr", 32'(rf_waddr), 32'd8);
    set_req(0, 1'b0, 4'd0, 16'h0000);
    tick();
    check_value("idle_we", 32'(rf_we), 32'd0);

    // 4: read hazard on an in-flight write
    do_reset();
    raddr_a = 4'd5;
    raddr_b = 4'd6;
    set_req(2, 1'b1, 4'd5, 16'h1234);
    #1;
    check_value("hz_ready", 32'(req_ready), 32'b100);
    tick();
    set_req(2, 1'b0, 4'd0, 16'h0000);
    check_value("hz_we",   32'(rf_we),     32'd1);
    check_value("hz_a",    32'(hazard_a),  32'd1);
    check_value("hz_b",    32'(hazard_b),  32'd0);
    check_value("hz_pend", 32'(pend_mask), 32'h0020);
    raddr_b = 4'd5;
    #1;
    check_value("hz_b_same", 32'(hazard_b), 32'd1);
    tick();
    check_value("hz_clear_a", 32'(hazard_a),    32'd0);
    check_value("hz_rf5",     32'(rf_model[5]), 32'h1234);
    raddr_a = '0;
    raddr_b = '0;

    // 5: two writers to the same register, later grant wins
    do_reset();
    set_req(0, 1'b1, 4'd7, 16'h0001);
    set_req(1, 1'b1, 4'd7, 16'h0002);
    #1;
    check_value("same_ready0", 32'(req_ready), 32'b001);
    tick();
    check_value("same_gid0",  32'(grant_id), 32'd0);
    check_value("same_data0", 32'(rf_wdata), 32'h0001);
    set_req(0, 1'b0, 4'd0, 16'h0000);
    #1;
    check_value("same_ready1", 32'(req_ready), 32'b010);
    tick();
    check_value("same_gid1",  32'(grant_id), 32'd1);
    check_value("same_data1", 32'(rf_wdata), 32'h0002);
    check_value("same_rf7a",  32'(rf_model[7]), 32'h0001);
    set_req(1, 1'b0, 4'd0, 16'h0000);
    tick();
    check_value("same_idle", 32'(rf_we),       32'd0);
    check_value("same_rf7b", 32'(rf_model[7]), 32'h0002);

    // 6a: flush the cycle after a handshake
    do_reset();
    set_req(1, 1'b1, 4'd9, 16'h0999);
    tick();
    check_value("fl_we", 32'(rf_we),    32'd1);
    check_value("fl_gid", 32'(grant_id), 32'd1);
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i + 1), rr_data[i]);
    flush = 1'b1;
    #1;
    check_value("fl_ready", 32'(req_ready), 32'b000);
    tick();
    flush = 1'b0;
    check_value("fl_we_drop", 32'(rf_we), 32'd0);
    #1;
    check_value("fl_ptr0", 32'(req_ready), 32'b001);
    tick();
    check_value("fl_after_we",  32'(rf_we),    32'd1);
    check_value("fl_after_gid", 32'(grant_id), 32'd0);

    // 6b: asynchronous reset while a write is in flight
    do_reset();
    set_req(2, 1'b1, 4'd10, 16'hBEEF);
    tick();
    check_value("ar_we", 32'(rf_we), 32'd1);
    set_req(2, 1'b0, 4'd0, 16'h0000);
    #2;
    rst_n = 1'b0;
    #1;
    check_value("ar_we_drop", 32'(rf_we),     32'd0);
    check_value("ar_pend",    32'(pend_mask), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check_value("ar_rf10",   32'(rf_model[10]), 32'h0000);
    check_value("ar_idle",   32'(rf_we),        32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
